// File: rtl/trace_unloader_pkg.sv
// trace_unloader_pkg
//   Shared DFD definitions for the trace unload path: the unloader FSM state
//   encoding and the serial bit order of trace words on the scan output.
package trace_unloader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    CAPT  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } trace_unload_state_t;

  // Trace words leave the scan output least-significant bit first.
  localparam bit TRACE_LSB_FIRST = 1'b1;

endpackage

// File: rtl/trace_shift_reg.sv
// trace_shift_reg
//   Parallel-load shift register for one trace word, with its own bit counter.
//   Ports:
//     clk, reset   clock, asynchronous active-high reset
//     load         load din and clear the bit counter
//     shift        consume one bit (shift one place, count it)
//     din          parallel trace word
//     bit_out      bit currently presented for serialization
//     last         the bit being presented is the final bit of the word
module trace_shift_reg #(
  parameter int Fpay = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            shift,
  input  logic [Fpay-1:0] din,
  output logic            bit_out,
  output logic            last
);
  import trace_unloader_pkg::*;

  localparam int CW = (Fpay > 1) ? $clog2(Fpay) : 1;

  logic [Fpay-1:0] sreg;
  logic [CW-1:0]   bit_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      sreg    <= din;
      bit_cnt <= '0;
    end else if (shift) begin
      sreg    <= TRACE_LSB_FIRST ? (sreg >> 1) : (sreg << 1);
      bit_cnt <= bit_cnt + CW'(1);
    end
  end

  assign bit_out = TRACE_LSB_FIRST ? sreg[0] : sreg[Fpay-1];
  assign last    = (bit_cnt == CW'(Fpay - 1));

endmodule

// File: rtl/trace_unloader.sv
// trace_unloader
//   Drains num_words trace words from the trace buffer read port and serializes
//   each one onto tdo, one bit per shift_en cycle. Owns the buffer read pointer
//   advance through tb_rd.
//   Ports:
//     clk, reset     clock, asynchronous active-high reset
//     start          request an unload (accepted only when idle)
//     num_words      words to unload, sampled with start
//     abort          cancel an unload in progress
//     tb_rd          trace buffer read strobe
//     tb_dout        trace buffer read data (valid the cycle after tb_rd)
//     shift_en       per-bit strobe from the TAP side
//     tdo, tdo_valid serial trace data and its qualifier
//     busy, done     activity flag and end-of-unload pulse
//     words_sent     words fully shifted in the current or last unload
//
//   state | meaning
//   IDLE  | waiting for start
//   REQ   | tb_rd high, buffer fetching the next word
//   CAPT  | tb_dout loaded into the shift register
//   SHIFT | word bits presented on tdo, one consumed per shift_en
//   DONE  | one-cycle done pulse
module trace_unloader #(
  parameter int Fpay  = 32,
  parameter int TB_Aw = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [TB_Aw:0]  num_words,
  input  logic            abort,
  output logic            tb_rd,
  input  logic [Fpay-1:0] tb_dout,
  input  logic            shift_en,
  output logic            tdo,
  output logic            tdo_valid,
  output logic            busy,
  output logic            done,
  output logic [TB_Aw:0]  words_sent
);
  import trace_unloader_pkg::*;

  trace_unload_state_t state, next_state;

  logic [TB_Aw:0] count;
  logic           load, shift, sr_bit, sr_last, word_done;

  trace_shift_reg #(.Fpay(Fpay)) u_sreg (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .shift   (shift),
    .din     (tb_dout),
    .bit_out (sr_bit),
    .last    (sr_last)
  );

  always_comb begin
    next_state = state;
    load       = 1'b0;
    shift      = 1'b0;
    case (state)
      IDLE:  if (start) next_state = (num_words == '0) ? DONE : REQ;
      REQ:   next_state = CAPT;
      CAPT: begin
        load       = 1'b1;
        next_state = SHIFT;
      end
      SHIFT: if (shift_en) begin
        shift = 1'b1;
        if (sr_last)
          next_state = ((words_sent + (TB_Aw+1)'(1)) == count) ? DONE : REQ;
      end
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
    // Abort overrides everything, including a final strobe in the same cycle,
    // so a word cut short on its last bit is not counted.
    if (abort && state != IDLE) begin
      next_state = IDLE;
      load       = 1'b0;
      shift      = 1'b0;
    end
  end

  assign word_done = shift && sr_last;

  // Outputs are registered from next_state so they line up with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tb_rd      <= 1'b0;
      tdo_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      words_sent <= '0;
      count      <= '0;
    end else begin
      state     <= next_state;
      tb_rd     <= (next_state == REQ);
      tdo_valid <= (next_state == SHIFT);
      busy      <= (next_state != IDLE);
      done      <= (next_state == DONE);
      if (state == IDLE && start) begin
        words_sent <= '0;
        count      <= num_words;
      end else if (word_done) begin
        words_sent <= words_sent + (TB_Aw+1)'(1);
      end
    end
  end

  assign tdo = (state == SHIFT) && sr_bit;

endmodule

// File: tb/tb_trace_unloader.sv
module tb_trace_unloader;
  localparam int FPAY = 32;
  localparam int AW   = 9;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [AW:0]     num_words = '0;
  logic            abort = 1'b0;
  logic            tb_rd;
  logic [FPAY-1:0] tb_dout = '0;
  logic            shift_en = 1'b0;
  logic            tdo, tdo_valid, busy, done;
  logic [AW:0]     words_sent;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:15];
  logic [31:0] got [0:7];
  int rp = 0;
  int rd_count = 0;

  trace_unloader #(.Fpay(FPAY), .TB_Aw(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_words  (num_words),
    .abort      (abort),
    .tb_rd      (tb_rd),
    .tb_dout    (tb_dout),
    .shift_en   (shift_en),
    .tdo        (tdo),
    .tdo_valid  (tdo_valid),
    .busy       (busy),
    .done       (done),
    .words_sent (words_sent)
  );

  always #5 clk = ~clk;

  // Trace buffer read port model: registered read, pointer advances on tb_rd.
  always @(posedge clk) begin
    if (tb_rd) begin
      tb_dout  <= mem[rp[3:0]];
      rp       <= rp + 1;
      rd_count <= rd_count + 1;
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({tb_rd, tdo, tdo_valid, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got rd/tdo/vld/busy/done=%b want 00000",
               {tb_rd, tdo, tdo_valid, busy, done});
    end
    checks++;
    if (words_sent !== 10'd0) begin
      errors++;
      $display("FAIL reset_words_sent got %0d want 0", words_sent);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_word();
    int base_rd;
    logic [31:0] w;
    w = mem[rp[3:0]];
    base_rd = rd_count;
    start = 1'b1; num_words = 10'd1; shift_en = 1'b1;
    for (int cyc = 1; cyc <= 36; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 1) begin
        checks++;
        if ({tb_rd, busy} !== 2'b11) begin
          errors++;
          $display("FAIL single_c1 got rd/busy=%b want 11", {tb_rd, busy});
        end
      end
      if (cyc == 2) begin
        checks++;
        if ({tb_rd, tdo_valid} !== 2'b00) begin
          errors++;
          $display("FAIL single_c2 got rd/vld=%b want 00", {tb_rd, tdo_valid});
        end
      end
      if (cyc >= 3 && cyc <= 34) begin
        checks++;
        if ({tdo_valid, tdo} !== {1'b1, w[cyc-3]}) begin
          errors++;
          $display("FAIL single_bit%0d got vld/tdo=%b want 1%b", cyc-3,
                   {tdo_valid, tdo}, w[cyc-3]);
        end
      end
      if (cyc == 35) begin
        checks++;
        if ({done, busy, tdo_valid} !== 3'b110 || words_sent !== 10'd1) begin
          errors++;
          $display("FAIL single_done got done/busy/vld=%b ws=%0d want 110 ws=1",
                   {done, busy, tdo_valid}, words_sent);
        end
      end
      if (cyc == 36) begin
        checks++;
        if ({done, busy} !== 2'b00) begin
          errors++;
          $display("FAIL single_idle got done/busy=%b want 00", {done, busy});
        end
      end
    end
    checks++;
    if (rd_count - base_rd != 1) begin
      errors++;
      $display("FAIL single_rd_pulses got %0d want 1", rd_count - base_rd);
    end
    shift_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_multi_toggle();
    int base_rd, base_rp, done_cnt, nbits, cyc;
    base_rd = rd_count; base_rp = rp; done_cnt = 0; nbits = 0; cyc = 0;
    for (int i = 0; i < 8; i++) got[i] = '0;
    start = 1'b1; num_words = 10'd3; shift_en = 1'b1;
    while (cyc < 400 && !(done_cnt > 0 && !busy)) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      shift_en = ~shift_en;
      if (tdo_valid && shift_en && nbits < 96) begin
        got[nbits/32][nbits%32] = tdo;
        nbits++;
      end
      if (done) done_cnt++;
    end
    checks++;
    if (cyc >= 400) begin
      errors++;
      $display("FAIL multi_timeout got %0d cycles want <400", cyc);
    end
    checks++;
    if (rd_count - base_rd != 3) begin
      errors++;
      $display("FAIL multi_rd_pulses got %0d want 3", rd_count - base_rd);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got[i] !== mem[(base_rp + i) % 16]) begin
        errors++;
        $display("FAIL multi_word%0d got %h want %h", i, got[i], mem[(base_rp + i) % 16]);
      end
    end
    checks++;
    if (nbits != 96 || done_cnt != 1 || words_sent !== 10'd3) begin
      errors++;
      $display("FAIL multi_totals got bits=%0d done=%0d ws=%0d want 96 1 3",
               nbits, done_cnt, words_sent);
    end
    shift_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero();
    int base_rd;
    base_rd = rd_count;
    start = 1'b1; num_words = 10'd0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({done, busy, tb_rd} !== 3'b110) begin
      errors++;
      $display("FAIL zero_c1 got done/busy/rd=%b want 110", {done, busy, tb_rd});
    end
    @(negedge clk);
    checks++;
    if ({done, busy, tb_rd} !== 3'b000) begin
      errors++;
      $display("FAIL zero_c2 got done/busy/rd=%b want 000", {done, busy, tb_rd});
    end
    checks++;
    if (rd_count != base_rd) begin
      errors++;
      $display("FAIL zero_rd_pulses got %0d want 0", rd_count - base_rd);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int base_rd, done_seen;
    base_rd = rd_count; done_seen = 0;
    start = 1'b1; num_words = 10'd4; shift_en = 1'b1;
    for (int cyc = 1; cyc <= 46; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) done_seen++;
    end
    @(negedge clk);            // cycle 47: 10 bits of word 2 consumed
    abort = 1'b1;
    checks++;
    if (tdo_valid !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre got vld=%b want 1", tdo_valid);
    end
    @(negedge clk);            // cycle 48
    abort = 1'b0;
    checks++;
    if ({busy, tdo_valid, tdo, done} !== 4'b0000 || words_sent !== 10'd1) begin
      errors++;
      $display("FAIL abort_idle got busy/vld/tdo/done=%b ws=%0d want 0000 ws=1",
               {busy, tdo_valid, tdo, done}, words_sent);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    checks++;
    if (done_seen != 0 || rd_count - base_rd != 2) begin
      errors++;
      $display("FAIL abort_no_done got done=%0d rd=%0d want 0 2",
               done_seen, rd_count - base_rd);
    end
    shift_en = 1'b0;
  endtask

  task automatic test_start_while_busy();
    int base_rd, first_done;
    base_rd = rd_count; first_done = -1;
    start = 1'b1; num_words = 10'd2; shift_en = 1'b1;
    for (int cyc = 1; cyc <= 75; cyc++) begin
      @(negedge clk);
      start = (cyc == 5);
      if (cyc == 5) num_words = 10'd5;
      if (done && first_done < 0) first_done = cyc;
    end
    start = 1'b0;
    checks++;
    if (first_done != 69) begin
      errors++;
      $display("FAIL busy_start_done_cycle got %0d want 69", first_done);
    end
    checks++;
    if (words_sent !== 10'd2 || rd_count - base_rd != 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_totals got ws=%0d rd=%0d busy=%b want 2 2 0",
               words_sent, rd_count - base_rd, busy);
    end
    shift_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    start = 1'b1; num_words = 10'd1; shift_en = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if ({busy, tdo_valid} !== 2'b11) begin
      errors++;
      $display("FAIL areset_pre got busy/vld=%b want 11", {busy, tdo_valid});
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({tb_rd, tdo, tdo_valid, busy, done} !== 5'b0 || words_sent !== 10'd0) begin
      errors++;
      $display("FAIL areset_outputs got rd/tdo/vld/busy/done=%b ws=%0d want 00000 ws=0",
               {tb_rd, tdo, tdo_valid, busy, done}, words_sent);
    end
    shift_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_single_word();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h1357_9BDF ^ (i * 32'h0101_0101);
    mem[0] = 32'hA5A5_0F0F;
    mem[1] = 32'hDEAD_BEEF;
    mem[2] = 32'h0123_4567;
    mem[3] = 32'h8000_0001;
    test_reset();
    test_single_word();
    test_multi_toggle();
    test_zero();
    test_abort();
    test_start_while_busy();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
